// File: rtl/instr_seq_pkg.sv
// Shared types for the MkII instruction source: sequencer states, the
// instruction word type and the default NOP encoding.
package instr_seq_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    localparam word_t NOP_CODE_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_store.sv
// Program memory for the instruction sequencer: one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module instr_store
    import instr_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  word_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output word_t                    rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Buffers a short program loaded over valid/ready and presents each word on
// machine_code for HOLD_CYCLES cycles, optionally looping.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int    DEPTH       = 16,
    parameter int    HOLD_CYCLES = 4,
    parameter word_t NOP_CODE    = NOP_CODE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [31:0]              load_data,
    output logic                     load_ready,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     loop_en,
    output logic [31:0]              machine_code,
    output logic                     instr_strobe,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    seq_state_t    state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [HW-1:0] hold_q, hold_d;
    word_t         mc_q, mc_d;
    logic          strobe_q, strobe_d;

    logic          we;
    logic [AW-1:0] rd_addr;
    word_t         rd_data;
    logic [AW:0]   pc_plus1;
    logic          has_next;
    logic          at_boundary;

    instr_store #(.DEPTH(DEPTH)) u_store (
        .clk   (clk),
        .we    (we),
        .waddr (count_q[AW-1:0]),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign pc_plus1    = {1'b0, pc_q} + 1'b1;
    assign has_next    = (pc_plus1 < count_q);
    assign at_boundary = (state_q == RUN) && (hold_q == HOLD_LAST);
    // Word 0 is read for start and for loop wrap; only a forward step reads pc+1.
    assign rd_addr     = (at_boundary && has_next) ? pc_plus1[AW-1:0] : '0;

    assign load_ready  = (state_q == IDLE) && (count_q < (AW+1)'(DEPTH)) && !start && !clear;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pc_d     = pc_q;
        hold_d   = hold_q;
        mc_d     = mc_q;
        strobe_d = 1'b0;
        we       = 1'b0;
        if (halt) begin
            state_d = IDLE;
            pc_d    = '0;
            hold_d  = '0;
            mc_d    = NOP_CODE;
        end else if (clear && (state_q != RUN)) begin
            state_d = IDLE;
            count_d = '0;
            pc_d    = '0;
            hold_d  = '0;
            mc_d    = NOP_CODE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start && (count_q != '0)) begin
                        state_d  = RUN;
                        pc_d     = '0;
                        hold_d   = '0;
                        mc_d     = rd_data;
                        strobe_d = 1'b1;
                    end else if (load_valid && load_ready) begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end
                RUN: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (has_next) begin
                            pc_d     = pc_plus1[AW-1:0];
                            mc_d     = rd_data;
                            strobe_d = 1'b1;
                        end else if (loop_en) begin
                            pc_d     = '0;
                            mc_d     = rd_data;
                            strobe_d = 1'b1;
                        end else begin
                            state_d = DONE;
                            mc_d    = NOP_CODE;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            pc_q     <= '0;
            hold_q   <= '0;
            mc_q     <= NOP_CODE;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            hold_q   <= hold_d;
            mc_q     <= mc_d;
            strobe_q <= strobe_d;
        end
    end

    assign machine_code = mc_q;
    assign instr_strobe = strobe_q;
    assign pc           = pc_q;
    assign count        = count_q;
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected strobed
// words (value, pc, cycle); a negedge monitor pops and compares them.
module tb_instr_sequencer;
    import instr_seq_pkg::*;

    localparam int DEPTH = 16;
    localparam int HOLD  = 4;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        loop_en = 1'b0;
    logic        load_ready;
    logic [31:0] machine_code;
    logic        instr_strobe;
    logic [3:0]  pc;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    instr_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .NOP_CODE(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .clear        (clear),
        .start        (start),
        .halt         (halt),
        .loop_en      (loop_en),
        .machine_code (machine_code),
        .instr_strobe (instr_strobe),
        .pc           (pc),
        .count        (count),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] w;
        int          pc;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_word(input logic [31:0] w, input int p, input int at);
        exp_t e;
        e.w = w;
        e.pc = p;
        e.at = at;
        sb.push_back(e);
    endtask

    task automatic goto(input int target);
        int n = 0;
        while (cyc < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("goto_cycle", 32'(cyc), 32'(target));
    endtask

    task automatic load_word(input logic [31:0] w);
        load_valid = 1'b1;
        load_data  = w;
        #1;
        check("load_ready_high", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic pulse(input int which);
        if (which == 0) start = 1'b1;
        else if (which == 1) clear = 1'b1;
        else halt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        halt  = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (reset === 1'b1 && instr_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got mc=%h pc=%0d at cycle %0d, expected no strobe",
                         machine_code, pc, cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("strobe cycle=%0d pc=%0d mc=%h", cyc, pc, machine_code);
                check("strobe_word", machine_code, mon_e.w);
                check("strobe_pc", 32'(pc), 32'(mon_e.pc));
                check("strobe_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    initial begin
        int t;
        #1;
        check("rst_mc", machine_code, NOP);
        check("rst_strobe", 32'(instr_strobe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Three words, each held 4 cycles, then DONE at +13 (cycle t+12).
        load_word(32'h0000_00A1);
        load_word(32'h0000_00B2);
        load_word(32'h0000_00C3);
        check("count_3", 32'(count), 32'd3);
        t = cyc + 1;
        expect_word(32'h0000_00A1, 0, t);
        expect_word(32'h0000_00B2, 1, t + 4);
        expect_word(32'h0000_00C3, 2, t + 8);
        pulse(0);
        check("run_busy", 32'(busy), 32'd1);
        goto(t + 11);
        check("last_word_held", machine_code, 32'h0000_00C3);
        check("not_done_yet", 32'(done), 32'd0);
        goto(t + 12);
        check("done_nop", machine_code, NOP);
        check("done_flag", 32'(done), 32'd1);
        check("done_not_busy", 32'(busy), 32'd0);
        check("sb_empty_1", 32'(sb.size()), 32'd0);

        // Fill to DEPTH, then a 17th offer is held off.
        pulse(1);
        check("clear_count", 32'(count), 32'd0);
        check("clear_done", 32'(done), 32'd0);
        for (int i = 0; i < DEPTH; i++) load_word(32'h1000_0000 + 32'(i));
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        #1;
        check("full_load_ready", 32'(load_ready), 32'd0);
        @(negedge clk);
        load_valid = 1'b0;
        check("full_count", 32'(count), 32'd16);
        t = cyc + 1;
        for (int i = 0; i < DEPTH; i++) expect_word(32'h1000_0000 + 32'(i), i, t + i * HOLD);
        pulse(0);
        goto(t + 63);
        check("full_last_word", machine_code, 32'h1000_000F);
        goto(t + 64);
        check("full_done", 32'(done), 32'd1);
        check("full_nop", machine_code, NOP);

        // Looping with two words; loop_en dropped during the second w1.
        pulse(1);
        load_word(32'h1111_0000);
        load_word(32'h2222_0001);
        loop_en = 1'b1;
        t = cyc + 1;
        expect_word(32'h1111_0000, 0, t);
        expect_word(32'h2222_0001, 1, t + 4);
        expect_word(32'h1111_0000, 0, t + 8);
        expect_word(32'h2222_0001, 1, t + 12);
        pulse(0);
        goto(t + 13);
        loop_en = 1'b0;
        goto(t + 15);
        check("loop_w1_held", machine_code, 32'h2222_0001);
        check("loop_not_done", 32'(done), 32'd0);
        goto(t + 16);
        check("loop_done", 32'(done), 32'd1);
        check("loop_nop", machine_code, NOP);
        check("sb_empty_2", 32'(sb.size()), 32'd0);

        // Halt in the second cycle of word 1, then restart from word 0.
        t = cyc + 1;
        expect_word(32'h1111_0000, 0, t);
        expect_word(32'h2222_0001, 1, t + 4);
        pulse(0);
        goto(t + 5);
        pulse(2);
        check("halt_nop", machine_code, NOP);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_done", 32'(done), 32'd0);
        check("halt_pc", 32'(pc), 32'd0);
        check("halt_count", 32'(count), 32'd2);
        repeat (6) @(negedge clk);
        t = cyc + 1;
        expect_word(32'h1111_0000, 0, t);
        expect_word(32'h2222_0001, 1, t + 4);
        pulse(0);
        goto(t + 8);
        check("rerun_done", 32'(done), 32'd1);

        // start and load_valid together: run begins, word not accepted.
        pulse(2);
        check("halt_from_done", 32'(done), 32'd0);
        t = cyc + 1;
        expect_word(32'h1111_0000, 0, t);
        expect_word(32'h2222_0001, 1, t + 4);
        start      = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'h0000_0BAD;
        #1;
        check("start_blocks_ready", 32'(load_ready), 32'd0);
        @(negedge clk);
        start      = 1'b0;
        load_valid = 1'b0;
        check("start_load_count", 32'(count), 32'd2);
        check("start_load_busy", 32'(busy), 32'd1);
        goto(t + 8);
        check("start_load_done", 32'(done), 32'd1);

        // start with an empty program stays IDLE.
        pulse(1);
        check("empty_count", 32'(count), 32'd0);
        pulse(0);
        check("empty_start_busy", 32'(busy), 32'd0);
        check("empty_start_done", 32'(done), 32'd0);
        @(negedge clk);
        check("empty_start_busy2", 32'(busy), 32'd0);

        // Asynchronous reset mid-run.
        load_word(32'h5A5A_0001);
        t = cyc + 1;
        expect_word(32'h5A5A_0001, 0, t);
        pulse(0);
        goto(t + 2);
        #2;
        reset = 1'b0;
        #1;
        check("areset_mc", machine_code, NOP);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_strobe", 32'(instr_strobe), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_count", 32'(count), 32'd0);
        check("post_reset_mc", machine_code, NOP);

        repeat (3) @(negedge clk);
        check("sb_empty_final", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
